// File: rtl/event_request_ctrl.sv
// event_request_ctrl: latches enabled event pulses per channel and arbitrates them onto one request/ack handshake.
// Define EVENT_REQUEST_CTRL_ROUND_ROBIN_EN for round-robin grant order; default is fixed lowest-index priority.
module event_request_ctrl #(
   parameter int N_EVENTS = 4,
   parameter int ID_BITS  = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_EVENTS-1:0] event_en,
   input  logic [N_EVENTS-1:0] event_pulse,
   input  logic [N_EVENTS-1:0] overrun_clr,
   output logic                tx_request,
   output logic [ID_BITS-1:0]  tx_event_id,
   input  logic                tx_ack,
   output logic [N_EVENTS-1:0] pending,
   output logic [N_EVENTS-1:0] overrun
);

   typedef enum logic {S_IDLE, S_REQ} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [N_EVENTS-1:0] r_pending;
   logic [N_EVENTS-1:0] r_overrun;
   logic [N_EVENTS-1:0] w_pending_nxt;
   logic [N_EVENTS-1:0] w_overrun_nxt;
   logic [N_EVENTS-1:0] w_ack_clr;
   logic [ID_BITS-1:0]  r_id;
   logic [ID_BITS-1:0]  w_id_nxt;
   logic [ID_BITS-1:0]  w_sel;
   logic                w_ack_hit;
   logic                w_any;

   // An ack only counts while a request is actually outstanding.
   assign w_ack_hit = tx_ack && (r_state == S_REQ);
   assign w_any     = |r_pending;

   always_comb begin
      w_ack_clr = '0;
      for (int i = 0; i < N_EVENTS; i++) begin
         w_ack_clr[i] = w_ack_hit && (r_id == ID_BITS'(i));
      end
   end

   assign w_pending_nxt = event_en & ((r_pending & ~w_ack_clr) | event_pulse);
   assign w_overrun_nxt = (event_en & event_pulse & r_pending & ~w_ack_clr)
                        | (r_overrun & ~overrun_clr);

`ifdef EVENT_REQUEST_CTRL_ROUND_ROBIN_EN
   logic [ID_BITS-1:0] r_last;

   // Walk the search order backwards so the closest channel after r_last wins.
   always_comb begin
      w_sel = '0;
      for (int k = N_EVENTS; k >= 1; k--) begin
         for (int i = 0; i < N_EVENTS; i++) begin
            if (r_pending[i] && (i == ((int'(r_last) + k) % N_EVENTS))) begin
               w_sel = ID_BITS'(i);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= ID_BITS'(N_EVENTS - 1);
      end else if ((r_state == S_IDLE) && w_any) begin
         r_last <= w_sel;
      end
   end
`else
   always_comb begin
      w_sel = '0;
      for (int i = N_EVENTS - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_sel = ID_BITS'(i);
         end
      end
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_id_nxt    = r_id;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt = S_REQ;
               w_id_nxt    = w_sel;
            end
         end
         S_REQ: begin
            if (w_ack_hit) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_id      <= '0;
         r_pending <= '0;
         r_overrun <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_id      <= w_id_nxt;
         r_pending <= w_pending_nxt;
         r_overrun <= w_overrun_nxt;
      end
   end

   assign tx_request  = (r_state == S_REQ);
   assign tx_event_id = r_id;
   assign pending     = r_pending;
   assign overrun     = r_overrun;

endmodule

// File: tb/tb_event_request_ctrl.sv
// Bench for event_request_ctrl: directed scenarios then random traffic, all checked against a behavioural model.
module tb_event_request_ctrl;

   localparam int N   = 4;
   localparam int IDB = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] event_en;
   logic [N-1:0] event_pulse;
   logic [N-1:0] overrun_clr;
   logic         tx_ack;
   logic         tx_request;
   logic [IDB-1:0] tx_event_id;
   logic [N-1:0] pending;
   logic [N-1:0] overrun;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   bit m_pend[N];
   bit m_ovr[N];
   bit m_req;
   int m_id;
   int m_last;

   always #5 clk = ~clk;

   event_request_ctrl #(.N_EVENTS(N), .ID_BITS(IDB)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .event_en   (event_en),
      .event_pulse(event_pulse),
      .overrun_clr(overrun_clr),
      .tx_request (tx_request),
      .tx_event_id(tx_event_id),
      .tx_ack     (tx_ack),
      .pending    (pending),
      .overrun    (overrun)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pack(input bit v[N]);
      logic [31:0] r = '0;
      for (int i = 0; i < N; i++) r[i] = v[i];
      return r;
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".req"}, 32'(tx_request), 32'(m_req));
      check({tag, ".id"},  32'(tx_event_id), 32'(m_id));
      check({tag, ".pend"}, 32'(pending), pack(m_pend));
      check({tag, ".ovr"},  32'(overrun), pack(m_ovr));
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0;
         m_ovr[i]  = 0;
      end
      m_req  = 0;
      m_id   = 0;
      m_last = N - 1;
   endtask

   function automatic int pick();
`ifdef EVENT_REQUEST_CTRL_ROUND_ROBIN_EN
      for (int k = 1; k <= N; k++) begin
         if (m_pend[(m_last + k) % N]) return (m_last + k) % N;
      end
`else
      for (int c = 0; c < N; c++) begin
         if (m_pend[c]) return c;
      end
`endif
      return 0;
   endfunction

   task automatic model_clock();
      bit ack;
      bit any;
      bit np[N];
      bit no[N];
      ack = tx_ack && m_req;
      any = 0;
      for (int i = 0; i < N; i++) begin
         bit served;
         served = ack && (m_id == i);
         np[i] = event_en[i] && ((m_pend[i] && !served) || event_pulse[i]);
         no[i] = (event_en[i] && event_pulse[i] && m_pend[i] && !served) || (m_ovr[i] && !overrun_clr[i]);
         if (m_pend[i]) any = 1;
      end
      if (m_req) begin
         if (ack) m_req = 0;
      end else if (any) begin
         m_id   = pick();
         m_last = m_id;
         m_req  = 1;
      end
      for (int i = 0; i < N; i++) begin
         m_pend[i] = np[i];
         m_ovr[i]  = no[i];
      end
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_clock();
      #1;
      check_all(tag);
   endtask

   task automatic step(input logic [N-1:0] en, input logic [N-1:0] pl, input logic [N-1:0] clr,
                       input logic ack, input string tag);
      event_en    = en;
      event_pulse = pl;
      overrun_clr = clr;
      tx_ack      = ack;
      cycle(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int grants;
      int first3;
      int age;
      int n;
      logic prev_req;

      rst_n       = 1'b0;
      event_en    = '0;
      event_pulse = '0;
      overrun_clr = '0;
      tx_ack      = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      rst_n = 1'b1;

      // Single event on channel 0
      step(4'b0001, 4'b0001, 4'b0000, 1'b0, "single.t0");
      check("single.pend0", 32'(pending[0]), 32'd1);
      step(4'b0001, 4'b0000, 4'b0000, 1'b0, "single.t1");
      check("single.req", 32'(tx_request), 32'd1);
      check("single.id0", 32'(tx_event_id), 32'd0);
      step(4'b0001, 4'b0000, 4'b0000, 1'b0, "single.t2");
      step(4'b0001, 4'b0000, 4'b0000, 1'b0, "single.t3");
      step(4'b0001, 4'b0000, 4'b0000, 1'b1, "single.ack");
      check("single.req_drop", 32'(tx_request), 32'd0);
      check("single.pend_clr", 32'(pending[0]), 32'd0);

      // Priority: channels 1 and 3 together
      step(4'b1111, 4'b1010, 4'b0000, 1'b0, "prio.pulse");
      step(4'b1111, 4'b0000, 4'b0000, 1'b0, "prio.req1");
      check("prio.first_id", 32'(tx_event_id), 32'd1);
      step(4'b1111, 4'b0000, 4'b0000, 1'b1, "prio.ack1");
      check("prio.gap", 32'(tx_request), 32'd0);
      step(4'b1111, 4'b0000, 4'b0000, 1'b0, "prio.req3");
      check("prio.second_id", 32'(tx_event_id), 32'd3);
      step(4'b1111, 4'b0000, 4'b0000, 1'b1, "prio.ack3");

      // Ack/pulse collision on channel 2, then a true overrun
      step(4'b1111, 4'b0100, 4'b0000, 1'b0, "coll.pulse");
      step(4'b1111, 4'b0000, 4'b0000, 1'b0, "coll.req");
      step(4'b1111, 4'b0100, 4'b0000, 1'b1, "coll.ack_pulse");
      check("coll.pend2_kept", 32'(pending[2]), 32'd1);
      check("coll.no_overrun", 32'(overrun[2]), 32'd0);
      step(4'b1111, 4'b0000, 4'b0000, 1'b0, "coll.rereq");
      check("coll.rereq_id", 32'(tx_event_id), 32'd2);
      step(4'b1111, 4'b0100, 4'b0000, 1'b0, "coll.early_pulse");
      check("coll.overrun_set", 32'(overrun[2]), 32'd1);
      step(4'b1111, 4'b0000, 4'b0000, 1'b1, "coll.ack2");
      step(4'b1111, 4'b0000, 4'b0000, 1'b0, "coll.hold");
      check("coll.overrun_sticky", 32'(overrun[2]), 32'd1);
      step(4'b1111, 4'b0000, 4'b0100, 1'b0, "coll.clr");
      check("coll.overrun_clr", 32'(overrun[2]), 32'd0);

      // Disable granted channel mid-request
      step(4'b1111, 4'b0001, 4'b0000, 1'b0, "dis.pulse");
      step(4'b1111, 4'b0000, 4'b0000, 1'b0, "dis.req");
      step(4'b1110, 4'b0000, 4'b0000, 1'b0, "dis.drop_en");
      check("dis.pend0_clr", 32'(pending[0]), 32'd0);
      check("dis.req_held", 32'(tx_request), 32'd1);
      step(4'b1110, 4'b0000, 4'b0000, 1'b0, "dis.hold");
      step(4'b1110, 4'b0000, 4'b0000, 1'b1, "dis.ack");
      step(4'b1110, 4'b0000, 4'b0000, 1'b0, "dis.idle");
      check("dis.no_rereq", 32'(tx_request), 32'd0);
      step(4'b1110, 4'b0000, 4'b0000, 1'b1, "dis.stray_ack");

      // Starvation: channel 0 pulsing every cycle, one pulse on channel 3
      grants   = 0;
      first3   = 0;
      age      = 0;
      prev_req = tx_request;
      n        = 0;
      while (grants < 8 && n < 200) begin
         step(4'b1111, (n == 0) ? 4'b1001 : 4'b0001, 4'b0000, (age == 2), "starve");
         if (m_req) age++;
         else age = 0;
         if (tx_request && !prev_req) begin
            grants++;
            if (tx_event_id == 2'd3 && first3 == 0) first3 = grants;
         end
         prev_req = tx_request;
         n++;
      end
      check("starve.grants", 32'(grants >= 8), 32'd1);
`ifdef EVENT_REQUEST_CTRL_ROUND_ROBIN_EN
      check("starve.id3_within4", 32'(first3 >= 1 && first3 <= 4), 32'd1);
`else
      check("starve.id3_never", 32'(first3), 32'd0);
`endif
      for (int i = 0; i < 12; i++) begin
         step(4'b1111, 4'b0000, 4'b0000, m_req, "drain");
      end

      // Asynchronous reset during a request with an overrun pending
      step(4'b1111, 4'b0010, 4'b0000, 1'b0, "arst.p1");
      step(4'b1111, 4'b0010, 4'b0000, 1'b0, "arst.p2");
      check("arst.pre_req", 32'(tx_request), 32'd1);
      check("arst.pre_ovr", 32'(overrun[1]), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("arst.req", 32'(tx_request), 32'd0);
      check("arst.pend", 32'(pending), 32'd0);
      check("arst.ovr", 32'(overrun), 32'd0);
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(4'b1111, 4'b0000, 4'b0000, 1'b0, "arst.quiet");
      end
      check("arst.no_req", 32'(tx_request), 32'd0);
      step(4'b1111, 4'b0100, 4'b0000, 1'b0, "arst.newpulse");
      step(4'b1111, 4'b0000, 4'b0000, 1'b0, "arst.newreq");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0] en;
         logic [N-1:0] pl;
         logic [N-1:0] cl;
         en = ($urandom_range(0, 7) == 0) ? N'($urandom) : {N{1'b1}};
         pl = N'($urandom) & N'($urandom);
         cl = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
         step(en, pl, cl, ($urandom_range(0, 2) == 0), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
